ps2_host_tx: RTL and testbench

//  Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset)
//  to the keyboard using the PS/2 request-to-send sequence. It is the reverse direction of the
//  PS/2 scan-code receiver. It drives open-drain enables (1 = pull line low) toward the pad

---
 rtl/ps2_host_tx.sv | 146 ++++++++++++++
 tb/tb_ps2_host_tx.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, shift a command byte out on the
// device's clock, then check the device ACK. Drives open-drain enables (1 = pull line low).
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       ps2_clk_drive_low,
  output logic       ps2_data_drive_low,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error
);
  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  // The RTS cycle is the last cycle of the clock hold, so INHIBIT itself lasts one cycle less.
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 2);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SHIFT, ACK, RELEASE} state_t;

  state_t            state_reg;
  logic [1:0]        pin_raw;
  logic [1:0]        sync_reg [2];
  logic              clk_prev_reg;
  logic              clk_s, data_s, fe, active, timed_out;
  logic [9:0]        shift_reg;
  logic [3:0]        bitcnt_reg;
  logic [INH_W-1:0]  inh_cnt_reg;
  logic [TO_W-1:0]   to_cnt_reg;

  assign pin_raw = {PS2_DATA, PS2_CLK};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
      always_ff @(posedge CLK) begin
        if (reset) sync_reg[gi] <= 2'b11;
        else       sync_reg[gi] <= {sync_reg[gi][0], pin_raw[gi]};
      end
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (reset) clk_prev_reg <= 1'b1;
    else       clk_prev_reg <= clk_s;
  end

  assign clk_s     = sync_reg[0][1];
  assign data_s    = sync_reg[1][1];
  assign fe        = clk_prev_reg & ~clk_s;
  assign active    = (state_reg == RTS) || (state_reg == SHIFT) ||
                     (state_reg == ACK) || (state_reg == RELEASE);
  assign timed_out = active && (to_cnt_reg == TO_LAST);

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_reg          <= IDLE;
      tx_ready           <= 1'b1;
      busy               <= 1'b0;
      ps2_clk_drive_low  <= 1'b0;
      ps2_data_drive_low <= 1'b0;
      tx_done            <= 1'b0;
      tx_error           <= 1'b0;
      shift_reg          <= '0;
      bitcnt_reg         <= '0;
      inh_cnt_reg        <= '0;
      to_cnt_reg         <= '0;
    end else begin
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
      if (active) to_cnt_reg <= to_cnt_reg + TO_W'(1);

      if (timed_out) begin
        state_reg          <= IDLE;
        tx_ready           <= 1'b1;
        busy               <= 1'b0;
        ps2_clk_drive_low  <= 1'b0;
        ps2_data_drive_low <= 1'b0;
        tx_error           <= 1'b1;
      end else begin
        case (state_reg)
          IDLE: begin
            if (tx_valid) begin
              shift_reg         <= {1'b1, ~^tx_data, tx_data};
              bitcnt_reg        <= '0;
              inh_cnt_reg       <= '0;
              ps2_clk_drive_low <= 1'b1;
              tx_ready          <= 1'b0;
              busy              <= 1'b1;
              state_reg         <= INHIBIT;
            end
          end
          INHIBIT: begin
            if (inh_cnt_reg == INH_LAST) begin
              ps2_data_drive_low <= 1'b1;
              to_cnt_reg         <= '0;
              state_reg          <= RTS;
            end else begin
              inh_cnt_reg <= inh_cnt_reg + INH_W'(1);
            end
          end
          RTS: begin
            ps2_clk_drive_low <= 1'b0;
            state_reg         <= SHIFT;
          end
          SHIFT: begin
            // Shifting ones in behind the stop bit keeps the line released once it is sent.
            if (fe) begin
              ps2_data_drive_low <= ~shift_reg[0];
              shift_reg          <= {1'b1, shift_reg[9:1]};
              bitcnt_reg         <= bitcnt_reg + 4'd1;
              if (bitcnt_reg == 4'd9) state_reg <= ACK;
            end
          end
          ACK: begin
            if (fe) begin
              if (!data_s) begin
                state_reg <= RELEASE;
              end else begin
                tx_error  <= 1'b1;
                tx_ready  <= 1'b1;
                busy      <= 1'b0;
                state_reg <= IDLE;
              end
            end
          end
          RELEASE: begin
            if (clk_s && data_s) begin
              tx_done   <= 1'b1;
              tx_ready  <= 1'b1;
              busy      <= 1'b0;
              state_reg <= IDLE;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks the frame out and a scoreboard compares
// the frame it reads, the completion pulses and the inhibit length with expected values.
module tb_ps2_host_tx;
  localparam int INH  = 20;
  localparam int TOUT = 5000;
  localparam int HALF = 100;

  typedef struct {
    logic [10:0] frame;
    logic [10:0] mask;
    bit          exp_done;
  } exp_t;

  logic       CLK = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, ps2_clk_drive_low, ps2_data_drive_low, busy, tx_done, tx_error;
  logic       dev_clk = 1'b1, dev_data = 1'b1;
  logic       ps2_clk_pin, ps2_data_pin;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, done_cnt = 0, err_cnt = 0, clk_low_cnt = 0, rts_cyc = 0, err_cyc = 0;
  int dev_falls = 0;
  exp_t exp_q[$];

  assign ps2_clk_pin  = dev_clk  & ~ps2_clk_drive_low;
  assign ps2_data_pin = dev_data & ~ps2_data_drive_low;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TOUT)) dut (
    .CLK(CLK), .reset(reset), .PS2_CLK(ps2_clk_pin), .PS2_DATA(ps2_data_pin),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .ps2_clk_drive_low(ps2_clk_drive_low), .ps2_data_drive_low(ps2_data_drive_low),
    .busy(busy), .tx_done(tx_done), .tx_error(tx_error)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (tx_done) done_cnt <= done_cnt + 1;
    if (tx_error) begin
      err_cnt <= err_cnt + 1;
      err_cyc <= cyc;
    end
    if (ps2_clk_drive_low) clk_low_cnt <= clk_low_cnt + 1;
    // Data pulled low while the clock is still held marks the RTS cycle.
    if (ps2_clk_drive_low && ps2_data_drive_low && rts_cyc != cyc) begin
      if (clk_low_cnt > 0) rts_cyc <= cyc;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  // mode 0 = ACK, 1 = NACK; nclk = number of clock pulses generated (11 for a full transfer).
  task automatic dev_run(input int mode, input int nclk, output logic [10:0] frame);
    int t;
    t = 0;
    frame = '1;
    dev_falls = 0;
    while (!(ps2_clk_pin === 1'b1 && ps2_data_pin === 1'b0) && t < 1000) begin
      @(negedge CLK);
      t++;
    end
    if (t >= 1000) return;
    frame[0] = ps2_data_pin;
    repeat (HALF) @(negedge CLK);
    for (int i = 1; i <= nclk && i <= 11; i++) begin
      dev_clk = 1'b0;
      dev_falls++;
      repeat (HALF) @(negedge CLK);
      dev_clk = 1'b1;
      if (i <= 10) frame[i] = ps2_data_pin;
      else dev_data = 1'b1;
      repeat (HALF / 2) @(negedge CLK);
      if (i == 10 && mode == 0) dev_data = 1'b0;
      repeat (HALF / 2) @(negedge CLK);
    end
    dev_clk  = 1'b1;
    dev_data = 1'b1;
  endtask

  task automatic do_xfer(input logic [7:0] d, input int mode, input int nclk);
    exp_t e, got;
    logic [10:0] fr;
    int d0, e0, c0, t;
    e.frame    = {1'b1, ~^d, d, 1'b0};
    e.mask     = (nclk >= 10) ? 11'h7FF : 11'h001;
    e.exp_done = (mode == 0 && nclk >= 11);
    exp_q.push_back(e);
    d0 = done_cnt; e0 = err_cnt; c0 = clk_low_cnt;
    n_cmp++;
    if (tx_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL ready_before_%h: tx_ready=%b required 1", d, tx_ready);
    end
    fork
      dev_run(mode, nclk, fr);
      begin
        @(negedge CLK);
        tx_data = d;
        tx_valid = 1'b1;
        @(negedge CLK);
        tx_valid = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || tx_ready !== 1'b0) begin
          n_bad++;
          $display("FAIL busy_%h: busy=%b tx_ready=%b required 1/0", d, busy, tx_ready);
        end
      end
    join
    t = 0;
    while (done_cnt + err_cnt == d0 + e0 && t < 8000) begin
      @(negedge CLK);
      t++;
    end
    repeat (20) @(negedge CLK);
    got = exp_q.pop_front();
    $display("xfer %h: frame=%b done=%0d err=%0d clk_low=%0d", d, fr, done_cnt - d0,
             err_cnt - e0, clk_low_cnt - c0);
    n_cmp++;
    if ((fr & got.mask) !== (got.frame & got.mask)) begin
      n_bad++;
      $display("FAIL frame_%h: read %b required %b (mask %b)", d, fr, got.frame, got.mask);
    end
    n_cmp++;
    if (done_cnt - d0 !== int'(got.exp_done)) begin
      n_bad++;
      $display("FAIL done_%h: %0d pulses required %0d", d, done_cnt - d0, int'(got.exp_done));
    end
    n_cmp++;
    if (err_cnt - e0 !== int'(!got.exp_done)) begin
      n_bad++;
      $display("FAIL error_%h: %0d pulses required %0d", d, err_cnt - e0, int'(!got.exp_done));
    end
    n_cmp++;
    if (clk_low_cnt - c0 !== INH) begin
      n_bad++;
      $display("FAIL inhibit_%h: clk held low %0d cycles required %0d", d, clk_low_cnt - c0, INH);
    end
    n_cmp++;
    if (tx_ready !== 1'b1 || ps2_clk_drive_low !== 1'b0 || ps2_data_drive_low !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_after_%h: ready=%b clk_dl=%b data_dl=%b required 1/0/0", d,
               tx_ready, ps2_clk_drive_low, ps2_data_drive_low);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge CLK);
    n_cmp++;
    if (tx_ready !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ready: ready=%b busy=%b required 1/0", tx_ready, busy);
    end
    n_cmp++;
    if (ps2_clk_drive_low !== 1'b0 || ps2_data_drive_low !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_lines: clk_dl=%b data_dl=%b required 0/0", ps2_clk_drive_low,
               ps2_data_drive_low);
    end
    n_cmp++;
    if (tx_done !== 1'b0 || tx_error !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_pulses: done=%b error=%b required 0/0", tx_done, tx_error);
    end
    reset = 1'b0;
    repeat (5) @(negedge CLK);
    $display("reset: ready=%b busy=%b", tx_ready, busy);
  endtask

  task automatic test_ack();
    do_xfer(8'hED, 0, 11);
    do_xfer(8'hF4, 0, 11);
  endtask

  task automatic test_nack();
    do_xfer(8'hFF, 1, 11);
  endtask

  task automatic test_timeout();
    do_xfer(8'h00, 0, 0);
    n_cmp++;
    if (err_cyc - rts_cyc !== TOUT) begin
      n_bad++;
      $display("FAIL timeout_delay: error %0d cycles after RTS required %0d", err_cyc - rts_cyc,
               TOUT);
    end
  endtask

  task automatic test_reset_abort();
    exp_t e;
    logic [10:0] fr;
    int d0, e0, t;
    e.frame = {1'b1, ~^8'hAA, 8'hAA, 1'b0};
    e.mask = 11'h00F;
    e.exp_done = 1'b0;
    exp_q.push_back(e);
    d0 = done_cnt; e0 = err_cnt;
    fork
      dev_run(0, 5, fr);
      begin
        @(negedge CLK);
        tx_data = 8'hAA;
        tx_valid = 1'b1;
        @(negedge CLK);
        tx_valid = 1'b0;
        t = 0;
        while (dev_falls < 2 && t < 2000) begin @(negedge CLK); t++; end
        repeat (10) @(negedge CLK);
        tx_data = 8'h55;
        tx_valid = 1'b1;
        @(negedge CLK);
        tx_valid = 1'b0;
        while (dev_falls < 4 && t < 2000) begin @(negedge CLK); t++; end
        repeat (10) @(negedge CLK);
        reset = 1'b1;
        @(negedge CLK);
        reset = 1'b0;
        n_cmp++;
        if (ps2_clk_drive_low !== 1'b0 || ps2_data_drive_low !== 1'b0 || tx_ready !== 1'b1) begin
          n_bad++;
          $display("FAIL abort_release: clk_dl=%b data_dl=%b ready=%b required 0/0/1",
                   ps2_clk_drive_low, ps2_data_drive_low, tx_ready);
        end
      end
    join
    repeat (50) @(negedge CLK);
    e = exp_q.pop_front();
    $display("abort AA: frame=%b done=%0d err=%0d", fr, done_cnt - d0, err_cnt - e0);
    n_cmp++;
    if ((fr & e.mask) !== (e.frame & e.mask)) begin
      n_bad++;
      $display("FAIL abort_bits: read %b required %b (mask %b)", fr, e.frame, e.mask);
    end
    n_cmp++;
    if (done_cnt != d0 || err_cnt != e0) begin
      n_bad++;
      $display("FAIL abort_pulses: done=%0d error=%0d required 0/0", done_cnt - d0, err_cnt - e0);
    end
    do_xfer(8'h00, 0, 11);
  endtask

  initial begin
    test_reset();
    test_ack();
    test_nack();
    test_timeout();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
